// File: rtl/systolic_pkg.sv
// Shared types and constants for the 4x4 systolic array feed path.
package systolic_pkg;

  localparam int ARRAY_N     = 4;
  localparam int DATA_WIDTH  = 16;
  localparam int FEED_CYCLES = 2 * ARRAY_N - 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Cycles after the last FEED cycle until PE(N-1,N-1) holds a final result.
  function automatic int drain_cycles(input int pe_latency);
    return ARRAY_N - 1 + pe_latency;
  endfunction

endpackage

// File: rtl/systolic_operand_buf.sv
// Holds one A and one B operand matrix (row-major) and presents the
// diagonally skewed left/top edge slices for feed step t.
module systolic_operand_buf
  import systolic_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int N  = ARRAY_N
) (
  input  logic                         clk_i,
  input  logic                         wr_en_i,
  input  logic                         wr_sel_i,   // 0: A, 1: B
  input  logic [$clog2(N*N)-1:0]       wr_idx_i,
  input  logic [DW-1:0]                wr_data_i,
  input  logic [2:0]                   rd_t_i,
  output logic [N*DW-1:0]              left_o,
  output logic [N*DW-1:0]              top_o,
  output logic [N-1:0]                 left_vld_o,
  output logic [N-1:0]                 top_vld_o
);

  localparam int AW = $clog2(N*N);

  logic [DW-1:0] a_mem [N*N];
  logic [DW-1:0] b_mem [N*N];

  // Storage is deliberately not reset; contents survive an aborted operation.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      if (wr_sel_i) b_mem[wr_idx_i] <= wr_data_i;
      else          a_mem[wr_idx_i] <= wr_data_i;
    end
  end

  // Edge lane i carries element k = t - i of its row (A) or column (B).
  always_comb begin
    int k;
    k          = 0;
    left_o     = '0;
    top_o      = '0;
    left_vld_o = '0;
    top_vld_o  = '0;
    for (int i = 0; i < N; i++) begin
      k = int'(rd_t_i) - i;
      if (k >= 0 && k < N) begin
        left_o[i*DW +: DW] = a_mem[AW'(i*N + k)];
        top_o[i*DW +: DW]  = b_mem[AW'(k*N + i)];
        left_vld_o[i]      = 1'b1;
        top_vld_o[i]       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/systolic_feed_controller.sv
// Loads A and B operand matrices, streams them skewed into a 4x4
// output-stationary systolic array, waits for drain and pulses done.
module systolic_feed_controller #(
  parameter int DATA_WIDTH = systolic_pkg::DATA_WIDTH,
  parameter int N          = systolic_pkg::ARRAY_N,
  parameter int PE_LATENCY = 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [DATA_WIDTH-1:0]   in_data_i,
  input  logic                    hold_i,
  output logic [N*DATA_WIDTH-1:0] left_data_o,
  output logic [N*DATA_WIDTH-1:0] top_data_o,
  output logic                    corner_valid_o,
  output logic [N-2:0]            left_valid_o,
  output logic [N-2:0]            top_valid_o,
  output logic                    pause_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [2:0]              state_o
);
  import systolic_pkg::*;

  localparam int FEED_LAST  = FEED_CYCLES - 1;
  localparam int DRAIN_LAST = drain_cycles(PE_LATENCY) - 1;
  localparam int WORD_LAST  = 2 * N * N - 1;

  state_e                  state_q, state_d;
  logic [5:0]              word_q, word_d;
  logic [2:0]              t_q, t_d;
  logic [3:0]              d_q, d_d;
  logic [N*DATA_WIDTH-1:0] ldata_q, ldata_d, tdata_q, tdata_d;
  logic [N-1:0]            lvld_q, lvld_d, tvld_q, tvld_d;

  logic [N*DATA_WIDTH-1:0] buf_left, buf_top;
  logic [N-1:0]            buf_lvld, buf_tvld;
  logic                    accept;

  // Operand handshake: a word transfers on a rising edge where in_valid_i and
  // in_ready_o are both high; in_ready_o is high exactly while in LOAD and
  // does not depend on in_valid_i.
  assign accept = in_valid_i & in_ready_o;

  systolic_operand_buf #(
    .DW (DATA_WIDTH),
    .N  (N)
  ) u_buf (
    .clk_i      (clk_i),
    .wr_en_i    (accept),
    .wr_sel_i   (word_q[4]),
    .wr_idx_i   (word_q[3:0]),
    .wr_data_i  (in_data_i),
    .rd_t_i     (t_d),
    .left_o     (buf_left),
    .top_o      (buf_top),
    .left_vld_o (buf_lvld),
    .top_vld_o  (buf_tvld)
  );

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    t_d     = t_q;
    d_d     = d_q;
    unique case (state_q)
      IDLE: begin
        word_d = '0;
        t_d    = '0;
        d_d    = '0;
        if (start_i) state_d = LOAD;
      end
      LOAD: begin
        if (accept) begin
          if (word_q == 6'(WORD_LAST)) begin
            state_d = FEED;
            word_d  = '0;
            t_d     = '0;
          end else begin
            word_d = word_q + 6'd1;
          end
        end
      end
      // hold defers every counter step and the exit transition alike.
      FEED: begin
        if (!hold_i) begin
          if (t_q == 3'(FEED_LAST)) begin
            state_d = DRAIN;
            d_d     = '0;
          end else begin
            t_d = t_q + 3'd1;
          end
        end
      end
      DRAIN: begin
        if (!hold_i) begin
          if (d_q == 4'(DRAIN_LAST)) state_d = DONE;
          else                       d_d = d_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Edge outputs are registered from the next state, so a frozen t repeats
  // the same slice while paused.
  always_comb begin
    ldata_d = '0;
    tdata_d = '0;
    lvld_d  = '0;
    tvld_d  = '0;
    if (state_d == FEED) begin
      ldata_d = buf_left;
      tdata_d = buf_top;
      lvld_d  = buf_lvld;
      tvld_d  = buf_tvld;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      word_q  <= '0;
      t_q     <= '0;
      d_q     <= '0;
      ldata_q <= '0;
      tdata_q <= '0;
      lvld_q  <= '0;
      tvld_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      t_q     <= t_d;
      d_q     <= d_d;
      ldata_q <= ldata_d;
      tdata_q <= tdata_d;
      lvld_q  <= lvld_d;
      tvld_q  <= tvld_d;
    end
  end

  assign in_ready_o     = (state_q == LOAD);
  assign pause_o        = hold_i & ((state_q == FEED) | (state_q == DRAIN));
  assign busy_o         = (state_q != IDLE);
  assign done_o         = (state_q == DONE);
  assign state_o        = state_q;
  assign left_data_o    = ldata_q;
  assign top_data_o     = tdata_q;
  assign corner_valid_o = lvld_q[0] & tvld_q[0];
  assign left_valid_o   = lvld_q[N-1:1];
  assign top_valid_o    = tvld_q[N-1:1];

endmodule

// File: tb/tb_systolic_feed_controller.sv
// Directed bench for systolic_feed_controller: edge-slice table, latency,
// hold, handshake gaps, reset abort and an array model for the product.
module tb_systolic_feed_controller;
  import systolic_pkg::*;

  localparam int DW = 16;
  localparam int N  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, start, in_valid, in_ready, hold;
  logic [DW-1:0]   in_data;
  logic [N*DW-1:0] left_data, top_data;
  logic            corner_valid, pause, busy, done;
  logic [N-2:0]    left_valid, top_valid;
  logic [2:0]      state;

  systolic_feed_controller dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .start_i        (start),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_data_i      (in_data),
    .hold_i         (hold),
    .left_data_o    (left_data),
    .top_data_o     (top_data),
    .corner_valid_o (corner_valid),
    .left_valid_o   (left_valid),
    .top_valid_o    (top_valid),
    .pause_o        (pause),
    .busy_o         (busy),
    .done_o         (done),
    .state_o        (state)
  );

  int checks  = 0;
  int errors  = 0;
  int cyc_cnt = 0;

  logic [DW-1:0] mat_a [16];
  logic [DW-1:0] mat_b [16];

  typedef struct {
    logic [63:0] left;
    logic [63:0] top;
    logic [6:0]  vld;   // {top_valid, left_valid, corner_valid}
  } vec_t;
  vec_t tbl [8];

  // ---------------- reference array model ----------------
  logic [39:0] acc  [4][4];
  logic [15:0] a_q  [4][4];
  logic [15:0] b_q  [4][4];
  logic        av_q [4][4];
  logic        bv_q [4][4];
  bit          model_clr = 1'b0;

  always @(negedge clk) begin
    logic [15:0] ain, bin;
    logic        av, bv;
    if (model_clr) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          acc[r][c] = '0; a_q[r][c] = '0; b_q[r][c] = '0;
          av_q[r][c] = 1'b0; bv_q[r][c] = 1'b0;
        end
    end else if (!pause) begin
      for (int r = 3; r >= 0; r--)
        for (int c = 3; c >= 0; c--) begin
          ain = (c == 0) ? left_data[r*16 +: 16] : a_q[r][c-1];
          av  = (c == 0) ? ((r == 0) ? corner_valid : left_valid[r-1]) : av_q[r][c-1];
          bin = (r == 0) ? top_data[c*16 +: 16] : b_q[r-1][c];
          bv  = (r == 0) ? ((c == 0) ? corner_valid : top_valid[c-1]) : bv_q[r-1][c];
          if (av && bv) acc[r][c] = acc[r][c] + 40'(ain) * 40'(bin);
          a_q[r][c] = ain; av_q[r][c] = av;
          b_q[r][c] = bin; bv_q[r][c] = bv;
        end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_cnt++;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc_cnt);
    end
  endtask

  task automatic check_vec(input string nm, input int idx);
    chk({nm, "_left"}, left_data, tbl[idx].left);
    chk({nm, "_top"},  top_data,  tbl[idx].top);
    chk({nm, "_vld"},  64'({top_valid, left_valid, corner_valid}), 64'(tbl[idx].vld));
  endtask

  task automatic check_zero_outputs(input string nm);
    chk({nm, "_state"}, 64'(state), 64'(IDLE));
    chk({nm, "_flags"}, 64'({in_ready, pause, busy, done}), 64'd0);
    chk({nm, "_vld"},   64'({top_valid, left_valid, corner_valid}), 64'd0);
    chk({nm, "_data"},  left_data | top_data, 64'd0);
  endtask

  task automatic clear_model();
    model_clr = 1'b1;
    cyc();
    model_clr = 1'b0;
  endtask

  task automatic start_op();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic load(input bit gappy, output int hs, output int ncyc);
    hs   = 0;
    ncyc = 0;
    while (hs < 32 && ncyc < 200) begin
      in_valid = gappy ? (ncyc % 2 == 0) : 1'b1;
      in_data  = !in_valid ? 16'hdead : (hs < 16) ? mat_a[hs] : mat_b[hs-16];
      if (in_valid && in_ready) hs++;
      cyc();
      ncyc++;
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_done(output int at);
    int n = 0;
    while (!done && n < 60) begin
      cyc();
      n++;
    end
    at = cyc_cnt;
    chk("done_seen", 64'(done), 64'd1);
  endtask

  task automatic check_product(input string nm);
    logic [39:0] g;
    int bad = 0;
    logic [39:0] bad_act = '0, bad_exp = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        g = '0;
        for (int k = 0; k < 4; k++) g = g + 40'(mat_a[r*4+k]) * 40'(mat_b[k*4+c]);
        if (acc[r][c] !== g && bad == 0) begin
          bad = 1; bad_act = acc[r][c]; bad_exp = g;
        end
      end
    chk(nm, 64'(bad_act), 64'(bad_exp));
  endtask

  function automatic logic [63:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  // ---------------- scenarios ----------------
  initial begin
    int hs, ncyc, feed_c, at;

    tbl[0] = '{pk(1, 0, 0, 0),   pk(17, 0, 0, 0),   7'b000_000_1};
    tbl[1] = '{pk(2, 5, 0, 0),   pk(21, 18, 0, 0),  7'b001_001_1};
    tbl[2] = '{pk(3, 6, 9, 0),   pk(25, 22, 19, 0), 7'b011_011_1};
    tbl[3] = '{pk(4, 7, 10, 13), pk(29, 26, 23, 20), 7'b111_111_1};
    tbl[4] = '{pk(0, 8, 11, 14), pk(0, 30, 27, 24), 7'b111_111_0};
    tbl[5] = '{pk(0, 0, 12, 15), pk(0, 0, 31, 28),  7'b110_110_0};
    tbl[6] = '{pk(0, 0, 0, 16),  pk(0, 0, 0, 32),   7'b100_100_0};
    tbl[7] = '{64'd0, 64'd0, 7'd0};
    for (int i = 0; i < 16; i++) begin
      mat_a[i] = 16'(i + 1);
      mat_b[i] = 16'(i + 17);
    end

    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; hold = 1'b1;
    cyc();
    cyc();
    reset = 1'b1;
    #1;
    check_zero_outputs("reset");
    cyc();
    chk("hold_in_idle_pause", 64'(pause), 64'd0);
    hold = 1'b0;

    // Basic feed table and completion latency.
    clear_model();
    start_op();
    chk("load_entry", 64'({state, in_ready}), 64'({LOAD, 1'b1}));
    load(1'b0, hs, ncyc);
    chk("load_words", 64'(hs), 64'd32);
    chk("feed_entry", 64'({state, in_ready}), 64'({FEED, 1'b0}));
    feed_c = cyc_cnt;
    for (int t = 0; t < 7; t++) begin
      check_vec($sformatf("feed_t%0d", t), t);
      cyc();
    end
    chk("drain_state", 64'(state), 64'(DRAIN));
    check_vec("drain", 7);
    wait_done(at);
    chk("done_latency", 64'(at - feed_c), 64'd11);
    chk("busy_at_done", 64'(busy), 64'd1);
    check_product("product_1");
    cyc();
    chk("done_one_cycle", 64'({done, busy}), 64'd0);

    // hold for 3 cycles at t=2 and once on the last feed cycle.
    clear_model();
    start_op();
    load(1'b0, hs, ncyc);
    feed_c = cyc_cnt;
    for (int t = 0; t < 2; t++) begin
      check_vec($sformatf("hfeed_t%0d", t), t);
      cyc();
    end
    hold = 1'b1;
    for (int h = 0; h < 3; h++) begin
      #1;
      chk($sformatf("hold_pause_%0d", h), 64'(pause), 64'd1);
      check_vec($sformatf("hold_frozen_%0d", h), 2);
      cyc();
    end
    hold = 1'b0;
    #1;
    chk("hold_release_pause", 64'(pause), 64'd0);
    check_vec("hold_after", 2);
    cyc();
    for (int t = 3; t < 6; t++) begin
      check_vec($sformatf("hfeed_t%0d", t), t);
      cyc();
    end
    check_vec("hfeed_t6", 6);
    hold = 1'b1;
    #1;
    chk("hold_last_pause", 64'(pause), 64'd1);
    cyc();
    hold = 1'b0;
    chk("hold_last_deferred", 64'(state), 64'(FEED));
    check_vec("hold_last_frozen", 6);
    cyc();
    chk("hold_last_drain", 64'(state), 64'(DRAIN));
    wait_done(at);
    chk("hold_done_latency", 64'(at - feed_c), 64'd15);
    check_product("product_hold");
    cyc();

    // Gapped load, stray start and in_valid during FEED.
    for (int i = 0; i < 16; i++) begin
      mat_a[i] = 16'(3 * i + 5);
      mat_b[i] = 16'(100 - 2 * i);
    end
    clear_model();
    chk("idle_not_ready", 64'(in_ready), 64'd0);
    start_op();
    load(1'b1, hs, ncyc);
    chk("gap_words", 64'(hs), 64'd32);
    chk("gap_cycles", 64'(ncyc), 64'd63);
    chk("gap_feed_entry", 64'(state), 64'(FEED));
    in_valid = 1'b1;
    in_data  = 16'hffff;
    for (int i = 0; i < 7; i++) begin
      start = (i % 2 == 0);
      cyc();
    end
    start    = 1'b0;
    in_valid = 1'b0;
    wait_done(at);
    check_product("product_gap");
    cyc();
    cyc();
    chk("stray_start_ignored", 64'({state, busy}), 64'({IDLE, 1'b0}));

    // Reset aborts an operation mid-FEED; a new operation then completes.
    clear_model();
    start_op();
    load(1'b0, hs, ncyc);
    cyc(); cyc(); cyc();
    chk("abort_at_t3", 64'({state, corner_valid}), 64'({FEED, 1'b1}));
    reset = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    check_zero_outputs("abort");
    cyc();
    chk("abort_no_done", 64'({done, busy}), 64'd0);
    clear_model();
    start_op();
    load(1'b0, hs, ncyc);
    feed_c = cyc_cnt;
    wait_done(at);
    chk("restart_latency", 64'(at - feed_c), 64'd11);
    check_product("product_restart");
    cyc();

    // start held high: DONE -> IDLE -> LOAD.
    for (int i = 0; i < 16; i++) begin
      mat_a[i] = 16'(i * i);
      mat_b[i] = 16'(16 - i);
    end
    clear_model();
    start = 1'b1;
    cyc();
    load(1'b0, hs, ncyc);
    wait_done(at);
    check_product("product_start_held");
    cyc();
    chk("held_idle", 64'(state), 64'(IDLE));
    cyc();
    chk("held_reload", 64'({state, in_ready}), 64'({LOAD, 1'b1}));
    start = 1'b0;
    reset = 1'b0;
    cyc();
    reset = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
